// File: rtl/udp_status_tx.sv
// UDP status transmitter: turns SDRAM read/write completion pulses into an
// 8-byte status packet and streams it into the UDP stack TX application port.
module udp_status_tx #(
   parameter int         PKT_LEN     = 8,
   parameter logic [7:0] HDR_BYTE    = 8'hA5,
   parameter int         ACK_TIMEOUT = 1024,
   parameter int         GAP_CYCLES  = 4
) (
   input  logic        udp_rx_clk,
   input  logic        reset,
   input  logic        read_finish,
   input  logic        write_finish,
   input  logic [31:0] cmd_word,
   input  logic        udp_tx_ready,
   input  logic        app_tx_ack,
   output logic        app_tx_data_request,
   output logic        app_tx_data_valid,
   output logic [7:0]  app_tx_data,
   output logic [15:0] app_tx_data_length,
   output logic        tx_busy,
   output logic [15:0] tx_count,
   output logic [7:0]  timeout_count
);

   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
   localparam int IDX_W  = $clog2(PKT_LEN + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

   state_t            state;
   logic [2:0]        rd_sync;
   logic [2:0]        wr_sync;
   logic              rise_rd;
   logic              rise_wr;
   logic              pend_rd;
   logic              pend_wr;
   logic [1:0]        pkt_type;
   logic [31:0]       shadow_cmd;
   logic [7:0]        seq;
   logic [WAIT_W-1:0] wait_cnt;
   logic [IDX_W-1:0]  byte_idx;
   logic [GAP_W-1:0]  gap_cnt;
   logic [7:0]        checksum;
   logic [7:0]        pkt_byte;

   // Two-flop synchronizer plus a third flop for rising-edge detection.
   always_ff @(posedge udp_rx_clk or negedge reset) begin
      if (!reset) begin
         rd_sync <= '0;
         wr_sync <= '0;
      end else begin
         rd_sync <= {rd_sync[1:0], read_finish};
         wr_sync <= {wr_sync[1:0], write_finish};
      end
   end

   assign rise_rd = rd_sync[1] & ~rd_sync[2];
   assign rise_wr = wr_sync[1] & ~wr_sync[2];

   assign checksum = HDR_BYTE ^ {6'b0, pkt_type} ^ shadow_cmd[31:24] ^ shadow_cmd[23:16]
                   ^ shadow_cmd[15:8] ^ shadow_cmd[7:0] ^ seq;

   always_comb begin
      pkt_byte = checksum;
      case (byte_idx)
         IDX_W'(0): pkt_byte = HDR_BYTE;
         IDX_W'(1): pkt_byte = {6'b0, pkt_type};
         IDX_W'(2): pkt_byte = shadow_cmd[31:24];
         IDX_W'(3): pkt_byte = shadow_cmd[23:16];
         IDX_W'(4): pkt_byte = shadow_cmd[15:8];
         IDX_W'(5): pkt_byte = shadow_cmd[7:0];
         IDX_W'(6): pkt_byte = seq;
         default:   pkt_byte = checksum;
      endcase
   end

   assign app_tx_data_length = 16'(PKT_LEN);
   assign tx_busy            = (state != IDLE);

   // Packet FSM; pending flags live here because the FSM both clears them on
   // capture and restores them when a request is abandoned.
   always_ff @(posedge udp_rx_clk or negedge reset) begin
      if (!reset) begin
         state               <= IDLE;
         pend_rd             <= 1'b0;
         pend_wr             <= 1'b0;
         pkt_type            <= '0;
         shadow_cmd          <= '0;
         seq                 <= '0;
         wait_cnt            <= '0;
         byte_idx            <= '0;
         gap_cnt             <= '0;
         app_tx_data_request <= 1'b0;
         app_tx_data_valid   <= 1'b0;
         app_tx_data         <= '0;
         tx_count            <= '0;
         timeout_count       <= '0;
      end else begin
         pend_rd <= pend_rd | rise_rd;
         pend_wr <= pend_wr | rise_wr;
         case (state)
            IDLE: begin
               if (pend_rd | pend_wr) begin
                  pkt_type            <= {pend_rd, pend_wr};
                  shadow_cmd          <= cmd_word;
                  pend_rd             <= rise_rd;
                  pend_wr             <= rise_wr;
                  wait_cnt            <= '0;
                  app_tx_data_request <= 1'b1;
                  state               <= REQ;
               end
            end
            REQ: begin
               if (udp_tx_ready && app_tx_ack) begin
                  app_tx_data_request <= 1'b0;
                  app_tx_data_valid   <= 1'b1;
                  app_tx_data         <= HDR_BYTE;
                  byte_idx            <= IDX_W'(1);
                  state               <= SEND;
               end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
                  app_tx_data_request <= 1'b0;
                  pend_rd             <= pend_rd | rise_rd | pkt_type[1];
                  pend_wr             <= pend_wr | rise_wr | pkt_type[0];
                  if (timeout_count != 8'hFF)
                     timeout_count <= timeout_count + 8'd1;
                  gap_cnt             <= '0;
                  state               <= GAP;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            SEND: begin
               if (byte_idx == IDX_W'(PKT_LEN)) begin
                  app_tx_data_valid <= 1'b0;
                  app_tx_data       <= '0;
                  seq               <= seq + 8'd1;
                  tx_count          <= tx_count + 16'd1;
                  gap_cnt           <= '0;
                  state             <= GAP;
               end else begin
                  app_tx_data <= pkt_byte;
                  byte_idx    <= byte_idx + IDX_W'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_status_tx.sv
// Directed self-checking bench for udp_status_tx; payload bytes are collected
// into a queue and compared against hand-computed packets.
module tb_udp_status_tx;

   logic        udp_rx_clk = 1'b0;
   logic        reset = 1'b0;
   logic        read_finish = 1'b0;
   logic        write_finish = 1'b0;
   logic [31:0] cmd_word = '0;
   logic        udp_tx_ready = 1'b1;
   logic        app_tx_ack = 1'b0;
   logic        app_tx_data_request;
   logic        app_tx_data_valid;
   logic [7:0]  app_tx_data;
   logic [15:0] app_tx_data_length;
   logic        tx_busy;
   logic [15:0] tx_count;
   logic [7:0]  timeout_count;

   int          testCount = 0;
   int          failCount = 0;
   int          reqCycles = 0;
   logic [7:0]  rxq[$];

   udp_status_tx dut (
      .udp_rx_clk(udp_rx_clk),
      .reset(reset),
      .read_finish(read_finish),
      .write_finish(write_finish),
      .cmd_word(cmd_word),
      .udp_tx_ready(udp_tx_ready),
      .app_tx_ack(app_tx_ack),
      .app_tx_data_request(app_tx_data_request),
      .app_tx_data_valid(app_tx_data_valid),
      .app_tx_data(app_tx_data),
      .app_tx_data_length(app_tx_data_length),
      .tx_busy(tx_busy),
      .tx_count(tx_count),
      .timeout_count(timeout_count)
   );

   always #5 udp_rx_clk = ~udp_rx_clk;

   // Collect every valid payload byte, sampled on the inactive edge.
   initial forever begin
      @(negedge udp_rx_clk);
      if (app_tx_data_valid) rxq.push_back(app_tx_data);
   end

   // UDP stack model: grant a request two cycles after it appears.
   initial forever begin
      @(negedge udp_rx_clk);
      if (app_tx_data_request) begin
         reqCycles++;
         app_tx_ack = (reqCycles >= 2);
      end else begin
         reqCycles  = 0;
         app_tx_ack = 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyReset();
      reset = 1'b0;
      read_finish = 1'b0;
      write_finish = 1'b0;
      udp_tx_ready = 1'b1;
      repeat (3) @(negedge udp_rx_clk);
      rxq.delete();
      reset = 1'b1;
      repeat (2) @(negedge udp_rx_clk);
   endtask

   task automatic waitBytes(input string tag, input int n, input int budget);
      int cycles = 0;
      while (rxq.size() < n && cycles < budget) begin
         @(negedge udp_rx_clk);
         cycles++;
      end
      if (rxq.size() < n) checkOutput({tag, "_timeout"}, rxq.size(), n);
   endtask

   task automatic waitValid(input string tag, input logic level);
      int cycles = 0;
      do begin
         @(negedge udp_rx_clk);
         cycles++;
      end while (app_tx_data_valid !== level && cycles < 3000);
      if (app_tx_data_valid !== level) checkOutput({tag, "_valid_wait"}, app_tx_data_valid, level);
   endtask

   task automatic pulseWrite(input int cycles);
      write_finish = 1'b1;
      repeat (cycles) @(negedge udp_rx_clk);
      write_finish = 1'b0;
   endtask

   task automatic checkPacket(input string tag, input int base, input logic [63:0] expected);
      logic [7:0] got;
      for (int i = 0; i < 8; i++) begin
         got = (base + i < rxq.size()) ? rxq[base + i] : 8'hXX;
         checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, expected[63 - 8*i -: 8]});
      end
   endtask

   task automatic applyStimulus();
      int count;

      // Reset state
      reset = 1'b0;
      #2;
      checkOutput("rst_request", app_tx_data_request, 1'b0);
      checkOutput("rst_valid", app_tx_data_valid, 1'b0);
      checkOutput("rst_data", app_tx_data, 8'h00);
      checkOutput("rst_busy", tx_busy, 1'b0);
      checkOutput("rst_txcount", tx_count, 16'd0);
      checkOutput("rst_timeouts", timeout_count, 8'd0);
      checkOutput("length", app_tx_data_length, 16'd8);

      // Write-done packet with latency check
      applyReset();
      cmd_word = 32'h0000_0042;
      write_finish = 1'b1;
      repeat (3) @(posedge udp_rx_clk);
      #1;
      checkOutput("lat_req_edge3", app_tx_data_request, 1'b0);
      write_finish = 1'b0;
      @(posedge udp_rx_clk);
      #1;
      checkOutput("lat_req_edge4", app_tx_data_request, 1'b1);
      checkOutput("lat_busy", tx_busy, 1'b1);
      waitBytes("wr", 8, 100);
      repeat (2) @(negedge udp_rx_clk);
      checkPacket("wr", 0, 64'hA5_01_00_00_00_42_00_E6);
      checkOutput("wr_txcount", tx_count, 16'd1);
      checkOutput("wr_timeouts", timeout_count, 8'd0);

      // Simultaneous read and write
      applyReset();
      cmd_word = 32'h1234_5678;
      read_finish = 1'b1;
      write_finish = 1'b1;
      repeat (2) @(negedge udp_rx_clk);
      read_finish = 1'b0;
      write_finish = 1'b0;
      waitBytes("both", 8, 100);
      repeat (50) @(negedge udp_rx_clk);
      checkPacket("both", 0, 64'hA5_03_12_34_56_78_00_AE);
      checkOutput("both_bytes", rxq.size(), 8);
      checkOutput("both_txcount", tx_count, 16'd1);

      // Read event during SEND of a write packet; cmd change must not leak
      applyReset();
      cmd_word = 32'h0000_0042;
      pulseWrite(3);
      waitValid("send", 1'b1);
      read_finish = 1'b1;
      cmd_word = 32'hDEAD_BEEF;
      repeat (2) @(negedge udp_rx_clk);
      read_finish = 1'b0;
      waitValid("send_end", 1'b0);
      count = 1;
      while (!app_tx_data_request && count < 100) begin
         @(negedge udp_rx_clk);
         if (!app_tx_data_request) count++;
      end
      checkOutput("gap_idle_cycles", count, 5);
      waitBytes("second", 16, 100);
      checkPacket("first", 0, 64'hA5_01_00_00_00_42_00_E6);
      checkPacket("second", 8, 64'hA5_02_DE_AD_BE_EF_01_84);

      // Sequence wrap over 257 packets
      applyReset();
      cmd_word = 32'h0000_0000;
      for (int k = 0; k < 257; k++) begin
         pulseWrite(2);
         waitBytes("wrap", 8 * (k + 1), 200);
      end
      repeat (3) @(negedge udp_rx_clk);
      checkOutput("seq_ff", {24'd0, (rxq.size() > 255*8+6) ? rxq[255*8+6] : 8'hXX}, 32'hFF);
      checkOutput("seq_wrap", {24'd0, (rxq.size() > 256*8+6) ? rxq[256*8+6] : 8'hXX}, 32'h00);
      checkOutput("wrap_txcount", tx_count, 16'd257);

      // Timeout and retry
      applyReset();
      udp_tx_ready = 1'b0;
      cmd_word = 32'h0000_0042;
      pulseWrite(2);
      count = 0;
      while (!app_tx_data_request && count < 50) begin
         @(negedge udp_rx_clk);
         count++;
      end
      count = 0;
      while (app_tx_data_request && count < 2000) begin
         @(negedge udp_rx_clk);
         count++;
      end
      checkOutput("to_req_cycles", count, 1024);
      checkOutput("to_count", timeout_count, 8'd1);
      checkOutput("to_txcount0", tx_count, 16'd0);
      udp_tx_ready = 1'b1;
      waitBytes("retry", 8, 100);
      repeat (2) @(negedge udp_rx_clk);
      checkPacket("retry", 0, 64'hA5_01_00_00_00_42_00_E6);
      checkOutput("retry_txcount", tx_count, 16'd1);

      // Held level produces one packet
      applyReset();
      pulseWrite(100);
      repeat (50) @(negedge udp_rx_clk);
      checkOutput("held_bytes", rxq.size(), 8);
      checkOutput("held_txcount", tx_count, 16'd1);

      // Reset mid-packet
      applyReset();
      cmd_word = 32'h0000_0042;
      pulseWrite(2);
      waitBytes("midrst", 3, 100);
      checkOutput("midrst_valid_pre", app_tx_data_valid, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("midrst_valid", app_tx_data_valid, 1'b0);
      checkOutput("midrst_request", app_tx_data_request, 1'b0);
      checkOutput("midrst_data", app_tx_data, 8'h00);
      @(negedge udp_rx_clk);
      count = rxq.size();
      reset = 1'b1;
      repeat (50) @(negedge udp_rx_clk);
      checkOutput("midrst_txcount", tx_count, 16'd0);
      checkOutput("midrst_nopkt", rxq.size(), count);
      cmd_word = 32'h0000_0007;
      pulseWrite(2);
      waitBytes("midrst_next", count + 8, 100);
      checkPacket("midrst_next", count, 64'hA5_01_00_00_00_07_00_A3);
   endtask

   initial begin
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got %0d checks, expected completion", testCount);
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/udp_status_tx.md
Name: udp_status_tx

Overview:
- UDP status/acknowledge transmitter; the return path for the UDP command receiver and decoder.
- Watches the SDRAM read_finish / write_finish completion pulses and builds a fixed 8-byte status packet.
- The packet echoes the command word that caused the transfer.
- Streams the packet byte-serially into the UDP stack TX application interface, using a request/ack handshake.

Parameters:
- PKT_LEN, 8: payload bytes per status packet. Fixed at 8; drives app_tx_data_length.
- HDR_BYTE, 8'hA5: constant first payload byte.
- ACK_TIMEOUT, 1024: cycles to wait in REQ for a grant before abandoning the attempt.
- GAP_CYCLES, 4: minimum idle cycles after the last byte before the next request.

Ports:
- udp_rx_clk, in, 1: clock for all logic.
- reset, in, 1: asynchronous, active-low.
- read_finish, in, 1: read-complete level/pulse from the SDRAM domain; asynchronous, synchronized internally.
- write_finish, in, 1: write-complete level/pulse from the SDRAM domain; asynchronous, synchronized internally.
- cmd_word, in, 32: currently decoded command word, echoed in the packet.
- udp_tx_ready, in, 1: UDP stack can accept a new packet.
- app_tx_ack, in, 1: UDP stack grants the current request.
- app_tx_data_request, out, 1: request to send one packet.
- app_tx_data_valid, out, 1: app_tx_data holds a valid payload byte.
- app_tx_data, out, 8: payload byte.
- app_tx_data_length, out, 16: payload length; constant PKT_LEN.
- tx_busy, out, 1: high in any state other than IDLE.
- tx_count, out, 16: completed packets, wraps at 16'hFFFF.
- timeout_count, out, 8: abandoned requests, saturates at 8'hFF.

Behaviour:
- Reset values (all outputs and state):
  - app_tx_data_request = 0, app_tx_data_valid = 0, app_tx_data = 0, tx_busy = 0, tx_count = 0, timeout_count = 0.
  - app_tx_data_length is constant PKT_LEN.
  - Synchronizers, pending flags and seq = 0; state = IDLE.
- Synchronization and edge detect:
  - Each finish input passes through 2 flops (s1, s2), then a third flop s3.
  - A rise is detected when s2 & ~s3.
  - A detected rise sets sticky flag pend_wr or pend_rd.
  - A level held high produces exactly one event.
- Latency: finish rises before edge 1 -> pending set at edge 3 -> state REQ with request = 1 after edge 4, provided the FSM is in IDLE.
- FSM states: IDLE, REQ, SEND, GAP.
- IDLE:
  - If pend_wr | pend_rd: capture type = {pend_rd, pend_wr} and cmd_word into shadow registers.
  - Clear the captured pend flags; go to REQ; request = 1.
  - A rise detected in this same cycle is kept pending, not lost.
- REQ:
  - Request held high.
  - If udp_tx_ready & app_tx_ack are sampled high: request = 0, go to SEND, byte index = 0.
  - Else if the wait counter reaches ACK_TIMEOUT-1: request = 0, OR the captured type back into the pend flags, timeout_count++ (saturating), go to GAP.
- SEND:
  - valid = 1 for exactly PKT_LEN consecutive cycles; there is no backpressure.
  - Byte order:
    - byte 0: HDR_BYTE.
    - byte 1: type, 8'h01 = write done, 8'h02 = read done, 8'h03 = both.
    - bytes 2-5: shadow cmd_word, MSB byte first.
    - byte 6: seq.
    - byte 7: XOR of bytes 0-6.
  - After byte 7: valid = 0, data = 0, seq++ (wraps 255 -> 0), tx_count++, go to GAP.
- GAP:
  - Count GAP_CYCLES cycles with valid = 0, then go to IDLE.
  - Events arriving during REQ, SEND or GAP set pend flags only; they become the next packet.
  - Multiple events of the same kind during one packet collapse into one.
- Simultaneous read and write rise: a single packet with type 8'h03.
- cmd_word changes after capture do not affect the packet in flight.
- Reset asserted mid-packet: all outputs clear immediately (asynchronous); the partial packet is abandoned; pending events are lost.
- tx_busy = (state != IDLE).

Test Plan:
- Write-done packet:
  - Stimulus: reset release; cmd_word = 32'h0000_0042; write_finish pulse of 3 cycles; udp_tx_ready = 1; ack 2 cycles after request.
  - Response: request high after edge 4; then 8 valid bytes A5 01 00 00 00 42 00 followed by XOR = E6; tx_count = 1.
- Both done together:
  - Stimulus: read_finish and write_finish rise on the same edge.
  - Response: one packet with type 03 and seq 00; no second packet.
- Events during SEND and sequence wrap:
  - Stimulus: read_finish rises during SEND of a write packet.
  - Response: second packet with type 02 and seq 01, sent after GAP_CYCLES idle.
  - Stimulus: 256 packets.
  - Response: seq wraps to 00.
- Timeout and retry:
  - Stimulus: udp_tx_ready held 0.
  - Response: request drops after ACK_TIMEOUT cycles; timeout_count = 1; after GAP, request re-asserts with the same type.
  - Stimulus: then grant.
  - Response: packet sent; tx_count = 1.
- Held level:
  - Stimulus: write_finish held high for 100 cycles.
  - Response: exactly one packet.
- Reset mid-packet:
  - Stimulus: assert reset at byte 3.
  - Response: valid, request and data are 0 the same cycle; after release, tx_count = 0, seq = 0, and no packet is sent.
